data_accumulator: RTL and testbench

- Captures fixed-length windows of signed 8-bit ADC samples, each window triggered by a capture strobe.
- Sums NUM_PASSES windows sample-by-sample into a 16-bit signed buffer, for waveform averaging.
- Then presents the summed buffer as a pop-on-read stream to a downstream reader, e.g. a host/UART packetiser.
- Sits between the ADC capture path and the readout logic.

---
 rtl/data_accumulator_if.sv | 28 ++
 rtl/data_accumulator.sv | 166 ++++++++++++++++
 tb/tb_data_accumulator.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_accumulator_if.sv
// Sample-in / summed-word-out bus between the ADC capture path, the accumulator and its reader.
// The master modport is the side that feeds samples and pops words; the slave modport is the accumulator.
interface data_accumulator_if;
    logic [7:0]  inputData;
    logic        dataCaptureStrobe;
    logic        dataRead;
    logic        dataReadyToRead;
    logic        dataEmpty;
    logic [15:0] dataOut;

    modport master (
        output inputData,
        output dataCaptureStrobe,
        output dataRead,
        input  dataReadyToRead,
        input  dataEmpty,
        input  dataOut
    );

    modport slave (
        input  inputData,
        input  dataCaptureStrobe,
        input  dataRead,
        output dataReadyToRead,
        output dataEmpty,
        output dataOut
    );
endinterface

// File: rtl/data_accumulator.sv
// Sums NUM_PASSES strobe-triggered windows of signed 8-bit samples into a 16-bit buffer,
// then streams the summed buffer out one word per pop.
module data_accumulator #(
    parameter int unsigned SAMPLES    = 128,
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned NUM_PASSES = 4
) (
    input  logic              clk,
    input  logic              rst,
    data_accumulator_if.slave acc
);
    localparam int unsigned IN_W   = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned PASS_W = $clog2(NUM_PASSES + 1);

    localparam logic [ADDR_W-1:0] FIRST_IDX = '0;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(SAMPLES - 1);
    localparam logic [PASS_W-1:0] PASS_MAX  = PASS_W'(NUM_PASSES);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        READOUT
    } stateType;

    stateType state, stateNext;

    logic [ADDR_W-1:0] captIdx, captIdxNext;
    logic [ADDR_W-1:0] readIdx, readIdxNext, readIdxInc;
    logic [PASS_W-1:0] passCount, passCountNext, passCountInc;

    logic              readyReg, readyNext;
    logic              emptyReg, emptyNext;
    logic [DATA_W-1:0] outReg, outNext;

    // Write pipeline stage: the sample captured on one edge is folded into the buffer on the next.
    logic              wrValid, wrValidNext;
    logic              wrFirst, wrFirstNext;
    logic [ADDR_W-1:0] wrIdx, wrIdxNext;
    logic [IN_W-1:0]   wrData, wrDataNext;
    logic [DATA_W-1:0] wrExt;

    logic [DATA_W-1:0] mem [SAMPLES];

    assign readIdxInc   = readIdx + 1'b1;
    assign passCountInc = passCount + 1'b1;
    assign wrExt        = {{(DATA_W - IN_W){wrData[IN_W-1]}}, wrData};

    assign acc.dataReadyToRead = readyReg;
    assign acc.dataEmpty       = emptyReg;
    assign acc.dataOut         = outReg;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state, counters, write stage and registered outputs
    always_comb begin
        stateNext     = state;
        captIdxNext   = captIdx;
        readIdxNext   = readIdx;
        passCountNext = passCount;
        readyNext     = readyReg;
        emptyNext     = emptyReg;
        outNext       = outReg;
        wrValidNext   = 1'b0;
        wrFirstNext   = wrFirst;
        wrIdxNext     = wrIdx;
        wrDataNext    = wrData;

        case (state)
            IDLE: begin
                readyNext   = 1'b0;
                outNext     = '0;
                readIdxNext = '0;
                emptyNext   = (passCount == '0);
                if (acc.dataCaptureStrobe) begin
                    stateNext   = CAPTURE;
                    wrValidNext = 1'b1;
                    wrIdxNext   = FIRST_IDX;
                    wrDataNext  = acc.inputData;
                    wrFirstNext = (passCount == '0);
                    captIdxNext = ADDR_W'(1);
                    emptyNext   = 1'b0;
                end
            end

            CAPTURE: begin
                wrValidNext = 1'b1;
                wrIdxNext   = captIdx;
                wrDataNext  = acc.inputData;
                captIdxNext = captIdx + 1'b1;
                emptyNext   = 1'b0;
                if (captIdx == LAST_IDX) begin
                    passCountNext = passCountInc;
                    stateNext     = (passCountInc >= PASS_MAX) ? READOUT : IDLE;
                end
            end

            READOUT: begin
                emptyNext = 1'b0;
                // First readout cycle loads word 0; the last sample write has landed by then.
                if (!readyReg) begin
                    readyNext   = 1'b1;
                    readIdxNext = FIRST_IDX;
                    outNext     = mem[FIRST_IDX];
                end else if (acc.dataRead) begin
                    if (readIdx == LAST_IDX) begin
                        stateNext     = IDLE;
                        readyNext     = 1'b0;
                        emptyNext     = 1'b1;
                        outNext       = '0;
                        passCountNext = '0;
                        readIdxNext   = '0;
                    end else begin
                        readIdxNext = readIdxInc;
                        outNext     = mem[readIdxInc];
                    end
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            captIdx   <= '0;
            readIdx   <= '0;
            passCount <= '0;
            readyReg  <= 1'b0;
            emptyReg  <= 1'b1;
            outReg    <= '0;
            wrValid   <= 1'b0;
            wrFirst   <= 1'b0;
            wrIdx     <= '0;
            wrData    <= '0;
        end else begin
            captIdx   <= captIdxNext;
            readIdx   <= readIdxNext;
            passCount <= passCountNext;
            readyReg  <= readyNext;
            emptyReg  <= emptyNext;
            outReg    <= outNext;
            wrValid   <= wrValidNext;
            wrFirst   <= wrFirstNext;
            wrIdx     <= wrIdxNext;
            wrData    <= wrDataNext;
        end
    end

    // Buffer: pass 0 overwrites stale contents, later passes add in two's complement
    always_ff @(posedge clk) begin
        if (wrValid) begin
            mem[wrIdx] <= wrFirst ? wrExt : (mem[wrIdx] + wrExt);
        end
    end
endmodule

// File: tb/tb_data_accumulator.sv
// Randomised scoreboard bench for data_accumulator: a 128-sample/4-pass instance and a
// 16-sample/256-pass instance for the range extremes.
module tb_data_accumulator;
    localparam int S   = 128;
    localparam int AW  = 7;
    localparam int NP  = 4;
    localparam int S2  = 16;
    localparam int AW2 = 4;
    localparam int NP2 = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;

    data_accumulator_if busA();
    data_accumulator_if busB();

    data_accumulator #(.SAMPLES(S), .ADDR_W(AW), .NUM_PASSES(NP)) dutA (
        .clk(clk),
        .rst(rst),
        .acc(busA)
    );

    data_accumulator #(.SAMPLES(S2), .ADDR_W(AW2), .NUM_PASSES(NP2)) dutB (
        .clk(clk),
        .rst(rst),
        .acc(busB)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int expA[$];
    int expB[$];
    int accA[S];
    int passA = 0;
    int monGotA, monExpA, monGotB, monExpB;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor A: every word popped by the reader must match the next expected sum
    always @(negedge clk) begin
        if (!rst && busA.dataReadyToRead && busA.dataRead) begin
            checks++;
            monGotA = $signed(busA.dataOut);
            if (expA.size() == 0) begin
                errors++;
                $display("FAIL popA: got word %0d but no word expected at %0t", monGotA, $time);
            end else begin
                monExpA = expA.pop_front();
                if (monGotA != monExpA) begin
                    errors++;
                    $display("FAIL popA: got %0d expected %0d at %0t", monGotA, monExpA, $time);
                end
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (!rst && busB.dataReadyToRead && busB.dataRead) begin
            checks++;
            monGotB = $signed(busB.dataOut);
            if (expB.size() == 0) begin
                errors++;
                $display("FAIL popB: got word %0d but no word expected at %0t", monGotB, $time);
            end else begin
                monExpB = expB.pop_front();
                if (monGotB != monExpB) begin
                    errors++;
                    $display("FAIL popB: got %0d expected %0d at %0t", monGotB, monExpB, $time);
                end
            end
        end
    end

    // One window on A: mode 0 constant, 1 ramp, 2 random; optional stray strobes mid-window
    task automatic windowA(input int mode, input int val, input bit junk);
        int smp[S];
        for (int i = 0; i < S; i++) begin
            case (mode)
                0:       smp[i] = val;
                1:       smp[i] = i - 64;
                default: smp[i] = int'($urandom_range(255)) - 128;
            endcase
            busA.inputData         = 8'(smp[i]);
            busA.dataCaptureStrobe = (i == 0) || (junk && ($urandom_range(2) == 0));
            @(posedge clk); #1;
        end
        busA.dataCaptureStrobe = 1'b0;
        for (int i = 0; i < S; i++) begin
            accA[i] = (passA == 0) ? smp[i] : accA[i] + smp[i];
        end
        passA++;
        if (passA == NP) begin
            for (int i = 0; i < S; i++) expA.push_back(accA[i]);
            passA = 0;
        end
    endtask

    task automatic betweenPassesA();
        check("emptyBetweenPasses", busA.dataEmpty, 0);
        check("readyBetweenPasses", busA.dataReadyToRead, 0);
    endtask

    // Drain A: hold dataRead high, or lag it one cycle behind dataReadyToRead
    task automatic readoutA(input bit lag, input bit junk);
        int n = 0;
        bit lastReady = 1'b0;
        for (int k = 0; k < 2 && !busA.dataReadyToRead; k++) begin
            @(posedge clk); #1;
        end
        check("readyLatencyA", busA.dataReadyToRead, 1);
        check("emptyInReadoutA", busA.dataEmpty, 0);
        while (busA.dataReadyToRead && n < S + 10) begin
            busA.dataRead = lag ? lastReady : 1'b1;
            lastReady = 1'b1;
            if (junk) busA.dataCaptureStrobe = (n >= S - 1) || ($urandom_range(1) == 1);
            @(posedge clk); #1;
            n++;
        end
        busA.dataCaptureStrobe = 1'b0;
        if (lag) begin
            busA.dataRead = 1'b1;
            @(posedge clk); #1;
        end
        busA.dataRead = 1'b0;
        check("readCyclesA", n, lag ? S + 1 : S);
        check("wordsLeftA", expA.size(), 0);
        check("readyAfterA", busA.dataReadyToRead, 0);
        check("emptyAfterA", busA.dataEmpty, 1);
        check("outAfterA", $signed(busA.dataOut), 0);
        repeat (3) @(posedge clk);
        #1;
        check("emptyStaysA", busA.dataEmpty, 1);
        check("readyStaysA", busA.dataReadyToRead, 0);
    endtask

    // NP2 constant windows on B, then a full drain
    task automatic runB(input int val);
        int n = 0;
        for (int p = 0; p < NP2; p++) begin
            for (int i = 0; i < S2; i++) begin
                busB.inputData         = 8'(val);
                busB.dataCaptureStrobe = (i == 0);
                @(posedge clk); #1;
            end
            busB.dataCaptureStrobe = 1'b0;
            if (p == 0) begin
                check("emptyBetweenB", busB.dataEmpty, 0);
                check("readyBetweenB", busB.dataReadyToRead, 0);
            end
        end
        for (int i = 0; i < S2; i++) expB.push_back(val * NP2);
        for (int k = 0; k < 2 && !busB.dataReadyToRead; k++) begin
            @(posedge clk); #1;
        end
        check("readyLatencyB", busB.dataReadyToRead, 1);
        while (busB.dataReadyToRead && n < S2 + 5) begin
            busB.dataRead = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        busB.dataRead = 1'b0;
        check("readCyclesB", n, S2);
        check("wordsLeftB", expB.size(), 0);
        check("emptyAfterB", busB.dataEmpty, 1);
    endtask

    initial begin
        busA.inputData = '0; busA.dataCaptureStrobe = 1'b0; busA.dataRead = 1'b0;
        busB.inputData = '0; busB.dataCaptureStrobe = 1'b0; busB.dataRead = 1'b0;

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("resetReadyA", busA.dataReadyToRead, 0);
        check("resetEmptyA", busA.dataEmpty, 1);
        check("resetOutA", $signed(busA.dataOut), 0);
        check("resetReadyB", busB.dataReadyToRead, 0);
        check("resetEmptyB", busB.dataEmpty, 1);
        check("resetOutB", $signed(busB.dataOut), 0);

        busA.dataRead = 1'b1;
        busB.dataRead = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("noPopAfterReset", busA.dataReadyToRead, 0);
            check("outIdleAfterReset", $signed(busA.dataOut), 0);
        end
        busA.dataRead = 1'b0;
        busB.dataRead = 1'b0;

        // Constant -3, strobes 250 clocks apart
        for (int p = 0; p < NP; p++) begin
            windowA(0, -3, 1'b0);
            if (p < NP - 1) begin
                betweenPassesA();
                repeat (122) @(posedge clk);
                #1;
            end
        end
        readoutA(1'b0, 1'b0);

        // Ramp with stray strobes during capture and readout
        for (int p = 0; p < NP; p++) begin
            windowA(1, 0, 1'b1);
            repeat ($urandom_range(5)) @(posedge clk);
            #1;
        end
        readoutA(1'b0, 1'b1);

        // Random samples, random gaps, lagging reader
        for (int p = 0; p < NP; p++) begin
            windowA(2, 0, 1'b0);
            repeat ($urandom_range(8)) @(posedge clk);
            #1;
        end
        readoutA(1'b1, 1'b0);

        // Reset in the middle of pass 2, then clean constant-5 accumulation
        windowA(2, 0, 1'b0);
        windowA(2, 0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            busA.inputData         = 8'($urandom_range(255));
            busA.dataCaptureStrobe = (i == 0);
            @(posedge clk); #1;
        end
        busA.dataCaptureStrobe = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        passA = 0;
        check("midResetEmpty", busA.dataEmpty, 1);
        check("midResetReady", busA.dataReadyToRead, 0);
        check("midResetOut", $signed(busA.dataOut), 0);
        for (int p = 0; p < NP; p++) windowA(0, 5, 1'b0);
        readoutA(1'b0, 1'b0);

        // Range extremes over 256 passes
        runB(-128);
        runB(127);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
